// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the lap stopwatch: FSM state encoding,
// per-digit radices, and the load-value clamp used by the countdown preset.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    localparam int RADIX_TENTHS = 10;
    localparam int RADIX_SEC_LO = 10;
    localparam int RADIX_SEC_HI = 6;
    localparam int RADIX_MIN    = 10;

    // Radix of digit position idx (0 = tenths); every minute digit is decimal.
    function automatic int radix_of(input int idx);
        if (idx == 0) begin
            return RADIX_TENTHS;
        end else if (idx == 1) begin
            return RADIX_SEC_LO;
        end else if (idx == 2) begin
            return RADIX_SEC_HI;
        end else begin
            return RADIX_MIN;
        end
    endfunction

    // Limit a raw nibble to the largest legal value of a digit with this radix.
    function automatic logic [3:0] clamp_bcd(input logic [3:0] val, input int radix);
        logic [3:0] top;
        top = 4'(radix - 1);
        return (val > top) ? top : val;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One counter digit of configurable radix. Increments or decrements when
// enabled; carry_o/borrow_o are combinational so a whole chain of digits
// ripples in a single cycle.
module bcd_digit #(
    parameter int RADIX = 10
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [3:0] digit_o,
    output logic       carry_o,
    output logic       borrow_o
);

    localparam logic [3:0] MAX_DIGIT = 4'(RADIX - 1);

    logic [3:0] digit_d;
    logic [3:0] digit_q;

    // Next digit value: clear beats load beats count.
    always_comb begin
        digit_d = digit_q;
        if (clr_i) begin
            digit_d = '0;
        end else if (load_i) begin
            digit_d = load_val_i;
        end else if (inc_i) begin
            digit_d = (digit_q == MAX_DIGIT) ? 4'd0 : digit_q + 4'd1;
        end else if (dec_i) begin
            digit_d = (digit_q == 4'd0) ? MAX_DIGIT : digit_q - 4'd1;
        end
    end

    // Digit register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o  = digit_q;
    assign carry_o  = inc_i && (digit_q == MAX_DIGIT);
    assign borrow_o = dec_i && (digit_q == 4'd0);

endmodule

// File: rtl/lap_stopwatch.sv
// BCD stopwatch core with tick prescaler, lap freeze and overflow pulse.
// Optional countdown mode (mode/load/preset ports, done pulse) is compiled
// in when the macro COUNTDOWN_EN is defined; the default build counts up only.
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter  int CLK_HZ     = 50_000_000,
    parameter  int TICK_HZ    = 10,
    parameter  int MIN_DIGITS = 1,
    localparam int DIGITS     = 3 + MIN_DIGITS
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_stop_i,
    input  logic                  clear_i,
    input  logic                  lap_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  running_o,
    output logic                  lap_o,
    output logic                  ovf_o
`ifdef COUNTDOWN_EN
    ,
    input  logic                  mode_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   load_val_i,
    output logic                  done_o
`endif
);

    localparam int                    PRESCALE = CLK_HZ / TICK_HZ;
    localparam int                    PRE_W    = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]      PRE_TERM = PRE_W'(PRESCALE - 1);
    localparam logic [4*DIGITS-1:0]   ONE_BCD  = (4*DIGITS)'(1);

    sw_state_e             state_q, state_d;
    logic [PRE_W-1:0]      prescale_q, prescale_d;
    logic                  lap_q, lap_d;
    logic [4*DIGITS-1:0]   snap_q, snap_d;
    logic                  mode_q, mode_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;

    logic                  mode_in;
    logic                  load_in;
    logic [4*DIGITS-1:0]   load_bus;

    logic [4*DIGITS-1:0]   live_bcd;
    logic [DIGITS:0]       inc_chain;
    logic [DIGITS:0]       dec_chain;
    logic                  tick;
    logic                  count_zero;
    logic                  count_one;
    logic                  digit_clr;
    logic                  digit_load;
    logic                  unused_borrow;

`ifdef COUNTDOWN_EN
    assign mode_in  = mode_i;
    assign load_in  = load_i;
    assign load_bus = load_val_i;
    assign done_o   = done_q;
`else
    logic unused_done;
    assign mode_in     = 1'b0;
    assign load_in     = 1'b0;
    assign load_bus    = '0;
    assign unused_done = done_q;
`endif

    assign count_zero = (live_bcd == '0);
    assign count_one  = (live_bcd == ONE_BCD);

    // A tick fires at prescaler terminal count in RUN; a start_stop or clear
    // pulse in that cycle wins and the prescaler holds instead.
    assign tick = (state_q == RUN) && !clear_i && !start_stop_i && (prescale_q == PRE_TERM);

    // Down-counting never steps below zero; done fires on the step 1 -> 0.
    assign inc_chain[0] = tick && !mode_q;
    assign dec_chain[0] = tick && mode_q && !count_zero;

    assign digit_clr  = clear_i;
    assign digit_load = load_in && !clear_i && !start_stop_i && (state_q == IDLE);

    // The top borrow can never assert because of the zero guard above.
    assign unused_borrow = dec_chain[DIGITS];

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        localparam int R = radix_of(i);
        logic [3:0] load_nibble;
        assign load_nibble = clamp_bcd(load_bus[4*i +: 4], R);

        bcd_digit #(.RADIX(R)) u_digit (
            .clk_i      (clk_i),
            .rst_n_i    (rst_n_i),
            .clr_i      (digit_clr),
            .load_i     (digit_load),
            .load_val_i (load_nibble),
            .inc_i      (inc_chain[i]),
            .dec_i      (dec_chain[i]),
            .digit_o    (live_bcd[4*i +: 4]),
            .carry_o    (inc_chain[i+1]),
            .borrow_o   (dec_chain[i+1])
        );
    end

    // Control next-state: clear > start_stop > lap, then prescaler and end-of-count events.
    always_comb begin
        state_d    = state_q;
        prescale_d = prescale_q;
        lap_d      = lap_q;
        snap_d     = snap_q;
        mode_d     = mode_q;
        ovf_d      = 1'b0;
        done_d     = 1'b0;

        if (clear_i) begin
            state_d    = IDLE;
            prescale_d = '0;
            lap_d      = 1'b0;
        end else if (start_stop_i) begin
            case (state_q)
                IDLE: begin
                    // A zero preset in down mode has nothing to count.
                    if (!(mode_in && count_zero)) begin
                        state_d    = RUN;
                        prescale_d = '0;
                        mode_d     = mode_in;
                    end
                end
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end else begin
            if (lap_i && (state_q != IDLE)) begin
                lap_d = !lap_q;
                // Capture the registered count, i.e. before any tick this cycle.
                if (!lap_q) begin
                    snap_d = live_bcd;
                end
            end
            if (state_q == RUN) begin
                prescale_d = tick ? '0 : prescale_q + 1'b1;
            end
        end

        if (inc_chain[DIGITS]) begin
            ovf_d = 1'b1;
        end

        // Countdown finished: back to IDLE showing the live zero.
        if (dec_chain[0] && count_one) begin
            done_d     = 1'b1;
            state_d    = IDLE;
            prescale_d = '0;
            lap_d      = 1'b0;
        end
    end

    // Control and snapshot registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            prescale_q <= '0;
            lap_q      <= 1'b0;
            snap_q     <= '0;
            mode_q     <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prescale_q <= prescale_d;
            lap_q      <= lap_d;
            snap_q     <= snap_d;
            mode_q     <= mode_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign bcd_o     = lap_q ? snap_q : live_bcd;
    assign running_o = (state_q == RUN);
    assign lap_o     = lap_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch at CLK_HZ=100, TICK_HZ=10 (10 clocks per tick),
// one minute digit. Countdown checks compile in with COUNTDOWN_EN.
module tb_lap_stopwatch;

    localparam int CLK_HZ     = 100;
    localparam int TICK_HZ    = 10;
    localparam int MIN_DIGITS = 1;
    localparam int DIGITS     = 3 + MIN_DIGITS;
    localparam int PRESCALE   = CLK_HZ / TICK_HZ;
    localparam int MAX_TENTHS = 6000;

    logic                clk_i = 1'b0;
    logic                rst_n_i = 1'b0;
    logic                start_stop_i = 1'b0;
    logic                clear_i = 1'b0;
    logic                lap_i = 1'b0;
    logic [4*DIGITS-1:0] bcd_o;
    logic                running_o;
    logic                lap_o;
    logic                ovf_o;
`ifdef COUNTDOWN_EN
    logic                mode_i = 1'b0;
    logic                load_i = 1'b0;
    logic [4*DIGITS-1:0] load_val_i = '0;
    logic                done_o;
`endif

    lap_stopwatch #(
        .CLK_HZ     (CLK_HZ),
        .TICK_HZ    (TICK_HZ),
        .MIN_DIGITS (MIN_DIGITS)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .start_stop_i (start_stop_i),
        .clear_i      (clear_i),
        .lap_i        (lap_i),
        .bcd_o        (bcd_o),
        .running_o    (running_o),
        .lap_o        (lap_o),
        .ovf_o        (ovf_o)
`ifdef COUNTDOWN_EN
        ,
        .mode_i       (mode_i),
        .load_i       (load_i),
        .load_val_i   (load_val_i),
        .done_o       (done_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: elapsed time as plain tenths of a second.
    int m_cnt, m_pre, m_snap, m_state;
    bit m_lap, m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] to_bcd(input int t);
        int secs, mins;
        secs = (t / 10) % 60;
        mins = t / 600;
        return {4'(mins % 10), 4'(secs / 10), 4'(secs % 10), 4'(t % 10)};
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_pre = 0; m_snap = 0; m_state = 0; m_lap = 0; m_ovf = 0;
    endtask

    // States: 0 idle, 1 run, 2 pause.
    task automatic model_step(input bit ss, input bit clr, input bit lp);
        m_ovf = 0;
        if (clr) begin
            m_state = 0; m_cnt = 0; m_pre = 0; m_lap = 0;
        end else if (ss) begin
            if (m_state == 0) begin m_state = 1; m_pre = 0; end
            else if (m_state == 1) m_state = 2;
            else m_state = 1;
        end else begin
            if (lp && m_state != 0) begin
                if (!m_lap) m_snap = m_cnt;
                m_lap = !m_lap;
            end
            if (m_state == 1) begin
                m_pre++;
                if (m_pre == PRESCALE) begin
                    m_pre = 0;
                    m_cnt++;
                    if (m_cnt == MAX_TENTHS) begin m_cnt = 0; m_ovf = 1; end
                end
            end
        end
    endtask

    task automatic cyc(input bit ss, input bit clr, input bit lp);
        start_stop_i = ss; clear_i = clr; lap_i = lp;
        @(posedge clk_i); #1;
        start_stop_i = 0; clear_i = 0; lap_i = 0;
        model_step(ss, clr, lp);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0);
    endtask

    typedef struct {
        bit          ss, clr, lp;
        logic [15:0] bcd;
        bit          run, lap;
    } vec_t;

    vec_t vecs[9];
    int   ovf_seen, ovf_at;

    initial begin
        model_reset();
        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_bcd", bcd_o, 0);
        check("rst_running", running_o, 0);
        check("rst_lap", lap_o, 0);
        check("rst_ovf", ovf_o, 0);
        rst_n_i = 1'b1;
        model_reset();

        // Control responses from reset, fewer cycles than one tick
        vecs[0] = '{0, 0, 1, 16'h0000, 0, 0}; // lap in IDLE ignored
        vecs[1] = '{1, 0, 0, 16'h0000, 1, 0}; // start
        vecs[2] = '{0, 0, 1, 16'h0000, 1, 1}; // lap on
        vecs[3] = '{0, 0, 1, 16'h0000, 1, 0}; // lap off
        vecs[4] = '{1, 0, 0, 16'h0000, 0, 0}; // pause
        vecs[5] = '{1, 0, 1, 16'h0000, 1, 0}; // resume, lap lower priority
        vecs[6] = '{1, 1, 0, 16'h0000, 0, 0}; // clear beats start_stop
        vecs[7] = '{1, 0, 0, 16'h0000, 1, 0}; // start
        vecs[8] = '{0, 1, 0, 16'h0000, 0, 0}; // clear
        for (int i = 0; i < 9; i++) begin
            cyc(vecs[i].ss, vecs[i].clr, vecs[i].lp);
            check($sformatf("vec%0d_bcd", i), bcd_o, vecs[i].bcd);
            check($sformatf("vec%0d_running", i), running_o, vecs[i].run);
            check($sformatf("vec%0d_lap", i), lap_o, vecs[i].lap);
        end

        // Full-range run: 1:00.0 after 6000 cycles, then wrap with one ovf pulse
        cyc(1, 0, 0);
        ovf_seen = 0; ovf_at = -1;
        for (int n = 1; n <= 60002; n++) begin
            cyc(0, 0, 0);
            if (ovf_o) begin ovf_seen++; ovf_at = n; end
            if (n == 5999)  check("t1_bcd_5999", bcd_o, 16'h0599);
            if (n == 6000) begin
                check("t1_bcd_6000", bcd_o, 16'h1000);
                check("t1_running", running_o, 1);
            end
            if (n == 59990) check("t2_bcd_max", bcd_o, 16'h9599);
            if (n == 60000) begin
                check("t2_bcd_wrap", bcd_o, 16'h0000);
                check("t2_ovf_pulse", ovf_o, 1);
                check("t2_running", running_o, 1);
            end
            if (n == 60001) check("t2_ovf_end", ovf_o, 0);
        end
        check("t2_ovf_count", ovf_seen, 1);
        check("t2_ovf_cycle", ovf_at, 60000);

        // Lap freeze while counting continues
        cyc(0, 1, 0);
        cyc(1, 0, 0);
        idle(1230);
        check("t3_live", bcd_o, 16'h0123);
        cyc(0, 0, 1);
        check("t3_lap_on", lap_o, 1);
        idle(500);
        check("t3_frozen", bcd_o, 16'h0123);
        check("t3_lap_held", lap_o, 1);
        cyc(0, 0, 1);
        check("t3_release", bcd_o, 16'h0173);
        check("t3_lap_off", lap_o, 0);

        // Pause mid-tick keeps the partial prescale
        cyc(0, 1, 0);
        cyc(1, 0, 0);
        idle(14);
        check("t4_before", bcd_o, 16'h0001);
        cyc(1, 0, 0);
        idle(100);
        check("t4_paused_bcd", bcd_o, 16'h0001);
        check("t4_paused_run", running_o, 0);
        cyc(1, 0, 0);
        idle(5);
        check("t4_resume5", bcd_o, 16'h0001);
        idle(1);
        check("t4_resume6", bcd_o, 16'h0002);

        // Clear + start_stop together, then asynchronous reset mid-run
        cyc(0, 0, 1);
        cyc(1, 1, 0);
        check("t5_bcd", bcd_o, 0);
        check("t5_running", running_o, 0);
        check("t5_lap", lap_o, 0);
        cyc(1, 0, 0);
        idle(25);
        cyc(0, 0, 1);
        check("t5_pre_rst", bcd_o, 16'h0002);
        #3 rst_n_i = 1'b0;
        #1;
        check("t5_rst_bcd", bcd_o, 0);
        check("t5_rst_running", running_o, 0);
        check("t5_rst_lap", lap_o, 0);
        check("t5_rst_ovf", ovf_o, 0);
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        model_reset();

`ifdef COUNTDOWN_EN
        // Countdown from a preset, then clamp of an illegal preset
        mode_i = 1'b1;
        load_val_i = 16'h0002; load_i = 1'b1;
        cyc(0, 0, 0);
        load_i = 1'b0;
        check("t6_loaded", bcd_o, 16'h0002);
        cyc(1, 0, 0);
        idle(10);
        check("t6_step1", bcd_o, 16'h0001);
        check("t6_no_done", done_o, 0);
        idle(10);
        check("t6_zero", bcd_o, 16'h0000);
        check("t6_done", done_o, 1);
        check("t6_idle", running_o, 0);
        check("t6_no_ovf", ovf_o, 0);
        idle(1);
        check("t6_done_end", done_o, 0);
        cyc(1, 0, 0);
        check("t6_zero_start", running_o, 0);
        load_val_i = 16'h07FF; load_i = 1'b1;
        cyc(0, 0, 0);
        load_i = 1'b0;
        check("t6_clamp", bcd_o, 16'h0599);
        mode_i = 1'b0;
        cyc(0, 1, 0);
        model_reset();
`endif

        // Random pulses against the reference model
        cyc(0, 1, 0);
        for (int i = 0; i < 3000; i++) begin
            bit ss, clr, lp;
            ss  = ($urandom_range(0, 39) == 0);
            clr = ($urandom_range(0, 249) == 0);
            lp  = ($urandom_range(0, 29) == 0);
            cyc(ss, clr, lp);
            check("rnd_bcd", bcd_o, m_lap ? to_bcd(m_snap) : to_bcd(m_cnt));
            check("rnd_running", running_o, (m_state == 1));
            check("rnd_lap", lap_o, m_lap);
            check("rnd_ovf", ovf_o, m_ovf);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
